// File: rtl/seq_det_ctrl.sv
// Run controller around a programmable Mealy serial sequence detector.
// Holds the pattern config, gates the serial input during a run, counts matches and reports completion.
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;
  logic [WIN_W-1:0] r_win;
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [WIN_W-1:0] r_bits;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic [PAT_W-1:0] w_seq;
  logic [PAT_W-1:0] w_mask;
  logic             w_fill_ok;
  logic             w_match;
  logic [WIN_W-1:0] w_bits_nxt;
  logic             w_win_hit;
  logic [LEN_W-1:0] w_fill_nxt;

  // Out-of-range lengths fall back to the full pattern width.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if ((len < LEN_W'(2)) || (len > LEN_W'(PAT_W))) begin
      clamp_len = LEN_W'(PAT_W);
    end else begin
      clamp_len = len;
    end
  endfunction

  // Match decode, window detection and next-value helpers.
  always_comb begin
    w_accept   = 1'b0;
    w_seq      = '0;
    w_mask     = '0;
    w_fill_ok  = 1'b0;
    w_match    = 1'b0;
    w_bits_nxt = '0;
    w_win_hit  = 1'b0;
    w_fill_nxt = '0;
    w_accept   = (r_state == S_RUN) && din_valid;
    w_seq      = {r_hist, din};
    // Wraps to all-ones when r_len == PAT_W.
    w_mask     = (PAT_W'(1) << r_len) - PAT_W'(1);
    w_fill_ok  = (r_fill >= (r_len - LEN_W'(1)));
    w_match    = w_accept && w_fill_ok && (((w_seq ^ r_pat) & w_mask) == '0);
    w_bits_nxt = r_bits + WIN_W'(1);
    w_win_hit  = w_accept && (r_win != '0) && (w_bits_nxt == r_win);
    if (r_fill == LEN_W'(PAT_W - 1)) begin
      w_fill_nxt = r_fill;
    end else begin
      w_fill_nxt = r_fill + LEN_W'(1);
    end
  end

  // Run-control FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_RUN;
          else       r_state <= S_IDLE;
        end
        S_RUN: begin
          if (abort || w_win_hit) r_state <= S_DONE;
          else                    r_state <= S_RUN;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Configuration registers, writable only outside a run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat <= PAT_W'(4'b1001);
      r_len <= LEN_W'(PAT_W);
      r_ovl <= 1'b0;
      r_win <= '0;
    end else if (cfg_we && (r_state != S_RUN)) begin
      r_pat <= cfg_pattern;
      r_len <= clamp_len(cfg_len);
      r_ovl <= cfg_overlap;
      r_win <= cfg_window;
    end else begin
      r_pat <= r_pat;
      r_len <= r_len;
      r_ovl <= r_ovl;
      r_win <= r_win;
    end
  end

  // Detector history, fill level, window bit count and match counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_bits <= '0;
      r_cnt  <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_hist <= '0;
      r_fill <= '0;
      r_bits <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_bits <= w_bits_nxt;
      if (w_match && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      // Non-overlapping mode must not reuse any bit of a completed match.
      if (w_match && !r_ovl) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_seq[PAT_W-2:0];
        r_fill <= w_fill_nxt;
      end
    end else begin
      r_hist <= r_hist;
      r_fill <= r_fill;
      r_bits <= r_bits;
      r_cnt  <= r_cnt;
    end
  end

  assign match       = w_match;
  assign match_count = r_cnt;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the detector rules.
module tb_seq_det_ctrl;

  logic       clk;
  logic       reset;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_window;
  logic       start;
  logic       abort;
  logic       din;
  logic       din_valid;
  logic       match;
  logic [7:0] match_count;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: phase 0 idle, 1 running, 2 done.
  int m_phase;
  int m_pat, m_len, m_ovl, m_win;
  int m_cnt, m_bits;
  int m_q[$];

  seq_det_ctrl #(.PAT_W(4), .LEN_W(3), .CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
    .start(start), .abort(abort), .din(din), .din_valid(din_valid),
    .match(match), .match_count(match_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pat = 9; m_len = 4; m_ovl = 0; m_win = 0;
    m_cnt = 0; m_bits = 0;
    m_q.delete();
  endtask

  task automatic model_cfg();
    m_pat = int'(cfg_pattern);
    m_len = ((cfg_len < 2) || (cfg_len > 4)) ? 4 : int'(cfg_len);
    m_ovl = int'(cfg_overlap);
    m_win = int'(cfg_window);
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance model past the edge.
  task automatic tick(input logic we, input logic st, input logic ab, input logic d, input logic dv);
    int v;
    int e_match;
    cfg_we = we; start = st; abort = ab; din = d; din_valid = dv;
    #3;
    e_match = 0;
    if ((m_phase == 1) && dv && (m_q.size() >= m_len - 1)) begin
      v = int'(d);
      for (int i = 1; i < m_len; i++) v = v | (m_q[m_q.size() - i] << i);
      e_match = (v == (m_pat & ((1 << m_len) - 1))) ? 1 : 0;
    end
    chk("match", match, e_match);
    chk("busy", busy, (m_phase == 1) ? 1 : 0);
    chk("done", done, (m_phase == 2) ? 1 : 0);
    chk("match_count", match_count, m_cnt);
    @(posedge clk);
    #1;
    if (m_phase == 0) begin
      if (we) model_cfg();
      if (st) begin
        m_cnt = 0; m_bits = 0; m_q.delete(); m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (dv) begin
        m_bits++;
        if (e_match != 0 && m_cnt < 255) m_cnt++;
        if (e_match != 0 && m_ovl == 0) m_q.delete();
        else begin
          m_q.push_back(int'(d));
          if (m_q.size() > 3) void'(m_q.pop_front());
        end
      end
      if (ab || (dv && m_win != 0 && m_bits == m_win)) m_phase = 2;
    end else begin
      if (we) model_cfg();
      m_phase = 0;
    end
    cfg_we = 1'b0; start = 1'b0; abort = 1'b0; din_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] p, input logic [2:0] l, input logic o, input logic [7:0] w);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_window = w;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) tick(1'b0, 1'b0, 1'b0, bits[i], 1'b1);
  endtask

  initial begin
    cfg_we = 0; start = 0; abort = 0; din = 0; din_valid = 0;
    set_cfg(4'b0000, 3'd0, 1'b0, 8'd0);
    reset = 1'b0;
    model_reset();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_count", match_count, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: default pattern, window 10, non-overlapping.
    set_cfg(4'b1001, 3'd4, 1'b0, 8'd10);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'b10_0100_1001, 10);
    chk("t1_done_pulse", done, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_count", match_count, 2);
    chk("t1_idle", done, 0);

    // 2: same stream overlapping.
    set_cfg(4'b1001, 3'd4, 1'b1, 8'd10);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'b10_0100_1001, 10);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_count", match_count, 3);

    // 3: 3-bit pattern, unlimited window, abort.
    set_cfg(4'b0110, 3'd3, 1'b0, 8'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'b11_0110, 6);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_count", match_count, 2);

    // 4: gaps inside 1001, start and cfg_we during the run are ignored.
    set_cfg(4'b1001, 3'd4, 1'b0, 8'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_cfg(4'b0010, 3'd2, 1'b1, 8'd3);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_count", match_count, 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'b1001, 4);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_cfg_kept", match_count, 1);

    // 5: saturation with 260 overlapping matches of "11".
    set_cfg(4'b0011, 3'd2, 1'b1, 8'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 261; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_saturate", match_count, 255);

    // 6: reset mid-run after 1,0,0 restores defaults and clears history.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'b100, 3);
    din = 1'b1; din_valid = 1'b1;
    reset = 1'b0;
    #2;
    model_reset();
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_match", match, 0);
    chk("t6_count", match_count, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    din_valid = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(16'b001, 3);
    chk("t6_default_pat", match_count, 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 7: random traffic including illegal lengths and stray control pulses.
    for (int i = 0; i < 2000; i++) begin
      set_cfg(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
      tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
